// File: rtl/regfile_pkg.sv
// Shared widths and the queued write-request record for the 16x16 register file.
package regfile_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 4'h0;

    typedef struct packed {
        logic [ADDR_W-1:0] reg_id;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/wl_decoder_4_16.sv
// Turns a register id into a one-hot write wordline; all-zero when disabled.
module wl_decoder_4_16
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0]   reg_id_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] wordline_o
);

    always_comb begin
        wordline_o = '0;
        if (en_i) begin
            wordline_o[reg_id_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_write_port.sv
// Write side of the register file: in-order write-back queue draining one wordline per cycle,
// with youngest-match bypass lookups for two read ports.
module reg_write_port
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_reg_id,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                wr_stall,
    output logic [NUM_REGS-1:0] wr_wordline,
    output logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_id_a,
    input  logic [ADDR_W-1:0]   rd_id_b,
    output logic                byp_hit_a,
    output logic [DATA_W-1:0]   byp_data_a,
    output logic                byp_hit_b,
    output logic [DATA_W-1:0]   byp_data_b,
    output logic                empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wr_entry_t         entries_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  idx;
    wr_entry_t         head;
    logic              push, enq, pop;

    // in_ready depends only on state, so a stall can never ripple back into the producer.
    assign in_ready = count_q < FULL_CNT;
    assign empty    = count_q == '0;
    assign push     = in_valid & in_ready;
    assign enq      = push & (in_reg_id != REG_ZERO);
    // Gating on rst keeps the head from landing in the register file while the queue is flushed.
    assign pop      = ~empty & ~wr_stall & ~rst;
    assign head     = entries_q[rd_ptr_q];
    assign wr_data  = pop ? head.data : '0;

    wl_decoder_4_16 u_wl_decoder (
        .reg_id_i   (head.reg_id),
        .en_i       (pop),
        .wordline_o (wr_wordline)
    );

    always_comb begin
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (enq) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            entries_q[wr_ptr_q] <= '{reg_id: in_reg_id, data: in_data};
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest pending write.
    always_comb begin
        byp_hit_a  = 1'b0;
        byp_data_a = '0;
        byp_hit_b  = 1'b0;
        byp_data_b = '0;
        idx        = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (valid_q[idx] && (entries_q[idx].reg_id == rd_id_a) && (rd_id_a != REG_ZERO)) begin
                byp_hit_a  = 1'b1;
                byp_data_a = entries_q[idx].data;
            end
            if (valid_q[idx] && (entries_q[idx].reg_id == rd_id_b) && (rd_id_b != REG_ZERO)) begin
                byp_hit_b  = 1'b1;
                byp_data_b = entries_q[idx].data;
            end
        end
    end

endmodule
